// File: rtl/cv32e40px_x_commit_tracker.sv
// cv32e40px_x_commit_tracker: coprocessor-side CORE-V-XIF scoreboard.
// Tracks each accepted offloaded instruction by id through commit or kill.
// It only passes committed results that write back to the core, through a
// one-deep output register.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   issue_*             issue channel observed from core/decoder
//   commit_*            commit channel (commit or kill by id)
//   ex_*                execution-unit result channel (valid/ready)
//   result_*            result channel towards the core (valid/ready)
//   outstanding_o       number of occupied slots
//   err_o               sticky protocol error
// Optional: define CV32E40PX_X_COMMIT_TRACKER_ERR_EN to build err_o
// detection; otherwise err_o is tied low.
module cv32e40px_x_commit_tracker #(
    parameter int X_ID_WIDTH  = 4,
    parameter int DEPTH       = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [X_ID_WIDTH-1:0]         issue_id_i,
    input  logic                          issue_accept_i,
    input  logic                          issue_writeback_i,
    input  logic                          commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]         commit_id_i,
    input  logic                          commit_kill_i,
    input  logic                          ex_valid_i,
    output logic                          ex_ready_o,
    input  logic [X_ID_WIDTH-1:0]         ex_id_i,
    input  logic [X_RFW_WIDTH-1:0]        ex_data_i,
    input  logic [4:0]                    ex_rd_i,
    input  logic [X_RFW_WIDTH/32-1:0]     ex_we_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [X_ID_WIDTH-1:0]         result_id_o,
    output logic [X_RFW_WIDTH-1:0]        result_data_o,
    output logic [4:0]                    result_rd_o,
    output logic [X_RFW_WIDTH/32-1:0]     result_we_o,
    output logic [$clog2(DEPTH+1)-1:0]    outstanding_o,
    output logic                          err_o
);
    localparam int WE_W  = X_RFW_WIDTH / 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_FREE      = 2'd0,
        S_ISSUED    = 2'd1,
        S_COMMITTED = 2'd2,
        S_KILLED    = 2'd3
    } slot_e;

    slot_e                  r_state [DEPTH];
    logic [X_ID_WIDTH-1:0]  r_id    [DEPTH];
    logic [DEPTH-1:0]       r_wb;

    logic                   r_res_valid;
    logic [X_ID_WIDTH-1:0]  r_res_id;
    logic [X_RFW_WIDTH-1:0] r_res_data;
    logic [4:0]             r_res_rd;
    logic [WE_W-1:0]        r_res_we;

    logic [DEPTH-1:0]       w_live;
    logic [DEPTH-1:0]       w_iss_hit;
    logic [DEPTH-1:0]       w_cmt_hit;
    logic [DEPTH-1:0]       w_ex_hit;
    logic [DEPTH-1:0]       w_alloc;
    slot_e                  w_ex_state;
    logic                   w_ex_wb;
    logic [CNT_W-1:0]       w_count;

    logic                   w_issue_ready;
    logic                   w_issue_fire;
    logic                   w_same;
    slot_e                  w_cmt_state;
    slot_e                  w_alloc_state;
    logic                   w_ex_ready;
    logic                   w_ex_fire;
    logic                   w_ex_load;

    // Ids are unique among live slots, so every hit vector is at most
    // one-hot and the ex lookup needs no priority.
    always_comb begin
        w_live     = '0;
        w_iss_hit  = '0;
        w_cmt_hit  = '0;
        w_ex_hit   = '0;
        w_alloc    = '0;
        w_ex_state = S_FREE;
        w_ex_wb    = 1'b0;
        w_count    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i]    = (r_state[i] != S_FREE);
            w_iss_hit[i] = w_live[i] && (r_id[i] == issue_id_i);
            w_cmt_hit[i] = w_live[i] && (r_id[i] == commit_id_i);
            w_ex_hit[i]  = w_live[i] && (r_id[i] == ex_id_i);
            if (w_ex_hit[i]) begin
                w_ex_state = r_state[i];
                w_ex_wb    = r_wb[i];
            end
            if (!w_live[i] && (w_alloc == '0)) begin
                w_alloc[i] = 1'b1;
            end
            w_count = w_count + CNT_W'(w_live[i]);
        end
    end

    assign w_issue_ready = (w_live != {DEPTH{1'b1}}) && (w_iss_hit == '0);
    assign w_issue_fire  = issue_valid_i && w_issue_ready && issue_accept_i;
    assign w_cmt_state   = commit_kill_i ? S_KILLED : S_COMMITTED;

    // A commit for an id issued in the same cycle has no slot yet; the
    // new slot is born already committed or killed.
    assign w_same        = commit_valid_i && (commit_id_i == issue_id_i);
    assign w_alloc_state = w_same ? w_cmt_state : S_ISSUED;

    // ISSUED slots stall ex: the result may still be killed.
    always_comb begin
        w_ex_ready = 1'b0;
        if (ex_valid_i) begin
            unique case (w_ex_state)
                S_KILLED:    w_ex_ready = 1'b1;
                S_COMMITTED: w_ex_ready = !w_ex_wb || !r_res_valid ||
                                          result_ready_i;
                default:     w_ex_ready = 1'b0;
            endcase
        end
    end

    assign w_ex_fire = ex_valid_i && w_ex_ready;
    assign w_ex_load = w_ex_fire && (w_ex_state == S_COMMITTED) && w_ex_wb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= S_FREE;
                r_id[i]    <= '0;
            end
            r_wb <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue_fire && w_alloc[i]) begin
                    r_state[i] <= w_alloc_state;
                    r_id[i]    <= issue_id_i;
                    r_wb[i]    <= issue_writeback_i;
                end else if (w_ex_fire && w_ex_hit[i]) begin
                    r_state[i] <= S_FREE;
                end else if (commit_valid_i && w_cmt_hit[i] &&
                             (r_state[i] == S_ISSUED)) begin
                    r_state[i] <= w_cmt_state;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            r_res_we    <= '0;
        end else if (w_ex_load) begin
            r_res_valid <= 1'b1;
            r_res_id    <= ex_id_i;
            r_res_data  <= ex_data_i;
            r_res_rd    <= ex_rd_i;
            r_res_we    <= ex_we_i;
        end else if (r_res_valid && result_ready_i) begin
            r_res_valid <= 1'b0;
        end
    end

    assign issue_ready_o  = w_issue_ready;
    assign ex_ready_o     = w_ex_ready;
    assign result_valid_o = r_res_valid;
    assign result_id_o    = r_res_id;
    assign result_data_o  = r_res_data;
    assign result_rd_o    = r_res_rd;
    assign result_we_o    = r_res_we;
    assign outstanding_o  = w_count;

`ifdef CV32E40PX_X_COMMIT_TRACKER_ERR_EN
    logic       r_err;
    logic [1:0] r_hold_cnt;
    logic       w_cmt_bad;
    logic       w_hold;
    logic       w_err_set;

    always_comb begin
        w_cmt_bad = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_cmt_hit[i] && (r_state[i] != S_ISSUED)) begin
                w_cmt_bad = 1'b1;
            end
        end
    end

    // r_hold_cnt counts earlier consecutive cycles of issue_valid_i on a
    // live id; the third such cycle flags the error.
    assign w_hold    = issue_valid_i && (w_iss_hit != '0);
    assign w_err_set = (commit_valid_i && (w_cmt_hit == '0) &&
                        !(w_issue_fire && w_same)) ||
                       (commit_valid_i && w_cmt_bad) ||
                       (ex_valid_i && (w_ex_hit == '0)) ||
                       (w_hold && (r_hold_cnt == 2'd2));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err      <= 1'b0;
            r_hold_cnt <= 2'd0;
        end else begin
            r_err <= r_err || w_err_set;
            if (!w_hold) begin
                r_hold_cnt <= 2'd0;
            end else if (r_hold_cnt != 2'd2) begin
                r_hold_cnt <= r_hold_cnt + 2'd1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40px_x_commit_tracker.sv
// tb_cv32e40px_x_commit_tracker: directed vector table, hand sequences and
// randomized traffic against a per-id reference model.
module tb_cv32e40px_x_commit_tracker;
    localparam int IDW   = 4;
    localparam int DEPTH = 4;
    localparam int M_FREE = 0;
    localparam int M_ISS  = 1;
    localparam int M_CMT  = 2;
    localparam int M_KIL  = 3;
`ifdef CV32E40PX_X_COMMIT_TRACKER_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           issue_valid_i, issue_ready_o;
    logic [IDW-1:0] issue_id_i;
    logic           issue_accept_i, issue_writeback_i;
    logic           commit_valid_i, commit_kill_i;
    logic [IDW-1:0] commit_id_i;
    logic           ex_valid_i, ex_ready_o;
    logic [IDW-1:0] ex_id_i;
    logic [31:0]    ex_data_i;
    logic [4:0]     ex_rd_i;
    logic [0:0]     ex_we_i;
    logic           result_valid_o, result_ready_i;
    logic [IDW-1:0] result_id_o;
    logic [31:0]    result_data_o;
    logic [4:0]     result_rd_o;
    logic [0:0]     result_we_o;
    logic [2:0]     outstanding_o;
    logic           err_o;

    int n_chk  = 0;
    int n_fail = 0;

    cv32e40px_x_commit_tracker #(
        .X_ID_WIDTH (IDW),
        .DEPTH      (DEPTH),
        .X_RFW_WIDTH(32)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_id_i       (issue_id_i),
        .issue_accept_i   (issue_accept_i),
        .issue_writeback_i(issue_writeback_i),
        .commit_valid_i   (commit_valid_i),
        .commit_id_i      (commit_id_i),
        .commit_kill_i    (commit_kill_i),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_id_i          (ex_id_i),
        .ex_data_i        (ex_data_i),
        .ex_rd_i          (ex_rd_i),
        .ex_we_i          (ex_we_i),
        .result_valid_o   (result_valid_o),
        .result_ready_i   (result_ready_i),
        .result_id_o      (result_id_o),
        .result_data_o    (result_data_o),
        .result_rd_o      (result_rd_o),
        .result_we_o      (result_we_o),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic iv; logic [3:0] iid; logic ia; logic iw;
        logic cv; logic [3:0] cid; logic ck;
        logic ev; logic [3:0] eid; logic [31:0] ed; logic [4:0] erd;
        logic rr;
        logic xir; logic xer; logic xrv; logic [3:0] xrid;
        logic [31:0] xrd; logic [4:0] xrrd; logic [2:0] xout;
    } vec_t;

    typedef struct {
        logic [3:0] id; logic [31:0] data; logic [4:0] rd;
    } res_t;

    vec_t tbl[$];
    int   m_st[16];
    bit   m_wb[16];
    res_t q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic vec_t v(
        int iv, int iid, int ia, int iw, int cv, int cid, int ck,
        int ev, int eid, logic [31:0] ed, int erd, int rr,
        int xir, int xer, int xrv, int xrid, logic [31:0] xrd,
        int xrrd, int xout);
        vec_t r;
        r.iv = 1'(iv);   r.iid = 4'(iid); r.ia = 1'(ia); r.iw = 1'(iw);
        r.cv = 1'(cv);   r.cid = 4'(cid); r.ck = 1'(ck);
        r.ev = 1'(ev);   r.eid = 4'(eid); r.ed = ed;   r.erd = 5'(erd);
        r.rr = 1'(rr);
        r.xir = 1'(xir); r.xer = 1'(xer); r.xrv = 1'(xrv);
        r.xrid = 4'(xrid); r.xrd = xrd; r.xrrd = 5'(xrrd);
        r.xout = 3'(xout);
        return r;
    endfunction

    task automatic drive(input logic iv, input logic [3:0] iid,
                         input logic ia, input logic iw,
                         input logic cv, input logic [3:0] cid,
                         input logic ck, input logic ev,
                         input logic [3:0] eid, input logic [31:0] ed,
                         input logic [4:0] erd, input logic rr);
        issue_valid_i = iv; issue_id_i = iid;
        issue_accept_i = ia; issue_writeback_i = iw;
        commit_valid_i = cv; commit_id_i = cid; commit_kill_i = ck;
        ex_valid_i = ev; ex_id_i = eid; ex_data_i = ed; ex_rd_i = erd;
        ex_we_i = 1'b1; result_ready_i = rr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    endtask

    initial begin
        // single-cycle flow: issue, commit, ex, result
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,3,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 1,3,0, 0,0,0,0, 1, 1,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,3,32'hDEADBEEF,5, 1,
                        1,1,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1,
                        1,0,1,3,32'hDEADBEEF,5,0));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        // ex before commit stalls
        tbl.push_back(v(1,2,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,2,32'h11111111,2, 1,
                        1,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 1,2,0, 1,2,32'h11111111,2, 1,
                        1,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,2,32'h11111111,2, 1,
                        1,1,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1,
                        1,0,1,2,32'h11111111,2,0));
        // killed result is dropped
        tbl.push_back(v(1,1,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 1,1,1, 0,0,0,0, 1, 1,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,1,32'h22222222,3, 1,
                        1,1,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        // rejected issue allocates nothing
        tbl.push_back(v(1,5,0,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        // fill all slots, id 4 waits for a free slot
        tbl.push_back(v(1,0,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,1,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,1));
        tbl.push_back(v(1,2,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,2));
        tbl.push_back(v(1,3,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,3));
        tbl.push_back(v(1,4,1,1, 0,0,0, 0,0,0,0, 1, 0,0,0,0,0,0,4));
        tbl.push_back(v(1,4,1,1, 1,0,0, 0,0,0,0, 1, 0,0,0,0,0,0,4));
        tbl.push_back(v(1,4,1,1, 0,0,0, 1,0,32'h33333333,4, 1,
                        0,1,0,0,0,0,4));
        tbl.push_back(v(1,4,1,1, 0,0,0, 0,0,0,0, 1,
                        1,0,1,0,32'h33333333,4,3));
        tbl.push_back(v(0,0,0,0, 1,1,1, 0,0,0,0, 1, 0,0,0,0,0,0,4));
        tbl.push_back(v(0,0,0,0, 1,2,1, 1,1,0,0, 1, 0,1,0,0,0,0,4));
        tbl.push_back(v(0,0,0,0, 1,3,1, 1,2,0,0, 1, 1,1,0,0,0,0,3));
        tbl.push_back(v(0,0,0,0, 1,4,1, 1,3,0,0, 1, 1,1,0,0,0,0,2));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,4,0,0, 1, 1,1,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        // result backpressure with ids 5 and 6
        tbl.push_back(v(1,5,1,1, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));
        tbl.push_back(v(1,6,1,1, 1,5,0, 0,0,0,0, 1, 1,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 1,6,0, 1,5,32'h55555555,7, 0,
                        1,1,0,0,0,0,2));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,6,32'h66666666,8, 0,
                        1,0,1,5,32'h55555555,7,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,6,32'h66666666,8, 0,
                        1,0,1,5,32'h55555555,7,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,6,32'h66666666,8, 1,
                        1,1,1,5,32'h55555555,7,1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1,
                        1,0,1,6,32'h66666666,8,0));
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,0, 1, 1,0,0,0,0,0,0));

        idle();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_rvalid", result_valid_o, 0);
        chk("rst_rid", result_id_o, 0);
        chk("rst_rdata", result_data_o, 0);
        chk("rst_rd", result_rd_o, 0);
        chk("rst_we", result_we_o, 0);
        chk("rst_out", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b0;

        foreach (tbl[k]) begin
            @(negedge clk_i);
            drive(tbl[k].iv, tbl[k].iid, tbl[k].ia, tbl[k].iw,
                  tbl[k].cv, tbl[k].cid, tbl[k].ck, tbl[k].ev,
                  tbl[k].eid, tbl[k].ed, tbl[k].erd, tbl[k].rr);
            #1;
            chk($sformatf("v%0d_iready", k), issue_ready_o, tbl[k].xir);
            chk($sformatf("v%0d_eready", k), ex_ready_o, tbl[k].xer);
            chk($sformatf("v%0d_rvalid", k), result_valid_o, tbl[k].xrv);
            chk($sformatf("v%0d_out", k), outstanding_o, tbl[k].xout);
            if (tbl[k].xrv) begin
                chk($sformatf("v%0d_rid", k), result_id_o, tbl[k].xrid);
                chk($sformatf("v%0d_rdata", k), result_data_o,
                    tbl[k].xrd);
                chk($sformatf("v%0d_rrd", k), result_rd_o, tbl[k].xrrd);
                chk($sformatf("v%0d_rwe", k), result_we_o, 1);
            end
        end
        chk("tbl_err", err_o, 0);

        // same-cycle issue and commit: slot born COMMITTED
        @(negedge clk_i);
        drive(1, 7, 1, 1, 1, 7, 0, 0, 0, 0, 0, 1);
        #1 chk("same_iready", issue_ready_o, 1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 9, 1);
        #1 chk("same_eready", ex_ready_o, 1);
        chk("same_out", outstanding_o, 1);
        @(negedge clk_i);
        idle();
        #1 chk("same_rvalid", result_valid_o, 1);
        chk("same_rid", result_id_o, 7);
        chk("same_rdata", result_data_o, 32'h77);
        // same-cycle issue and kill: slot born KILLED
        @(negedge clk_i);
        drive(1, 8, 1, 1, 1, 8, 1, 0, 0, 0, 0, 1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h88, 9, 1);
        #1 chk("samek_eready", ex_ready_o, 1);
        @(negedge clk_i);
        idle();
        #1 chk("samek_rvalid", result_valid_o, 0);
        chk("samek_out", outstanding_o, 0);
        // ex for an unknown id never handshakes
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 32'h1, 1, 1);
        #1 chk("nomatch_eready", ex_ready_o, 0);

        // reset mid-operation drops entries and output register
        @(negedge clk_i);
        drive(1, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk_i);
        drive(1, 10, 1, 1, 1, 9, 0, 0, 0, 0, 0, 1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 9, 1);
        @(negedge clk_i);
        idle();
        #1 chk("pre_rst_rvalid", result_valid_o, 1);
        chk("pre_rst_out", outstanding_o, 1);
        rst_i = 1'b1;
        #1 chk("mid_rst_rvalid", result_valid_o, 0);
        chk("mid_rst_out", outstanding_o, 0);
        chk("mid_rst_rid", result_id_o, 0);
        chk("mid_rst_iready", issue_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            m_st[i] = M_FREE;
            m_wb[i] = 1'b0;
        end
        q.delete();

        for (int c = 0; c < 600; c++) begin
            int   nlive;
            int   st;
            logic xir, xer;
            @(negedge clk_i);
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                  32'($urandom), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) != 0));
            #1;
            nlive = 0;
            for (int i = 0; i < 16; i++) begin
                if (m_st[i] != M_FREE) nlive++;
            end
            xir = (nlive < DEPTH) && (m_st[issue_id_i] == M_FREE);
            st  = m_st[ex_id_i];
            xer = ex_valid_i &&
                  ((st == M_KIL) ||
                   ((st == M_CMT) && (!m_wb[ex_id_i] ||
                    (q.size() == 0) || result_ready_i)));
            chk("rnd_iready", issue_ready_o, xir);
            chk("rnd_eready", ex_ready_o, xer);
            chk("rnd_out", outstanding_o, nlive);
            chk("rnd_rvalid", result_valid_o, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd_rid", result_id_o, q[0].id);
                chk("rnd_rdata", result_data_o, q[0].data);
                chk("rnd_rrd", result_rd_o, q[0].rd);
            end
            if ((q.size() != 0) && result_ready_i) void'(q.pop_front());
            if (xer) begin
                if ((st == M_CMT) && m_wb[ex_id_i]) begin
                    q.push_back('{ex_id_i, ex_data_i, ex_rd_i});
                end
                m_st[ex_id_i] = M_FREE;
            end
            if (commit_valid_i && (m_st[commit_id_i] == M_ISS)) begin
                m_st[commit_id_i] = commit_kill_i ? M_KIL : M_CMT;
            end
            if (issue_valid_i && xir && issue_accept_i) begin
                if (commit_valid_i && (commit_id_i == issue_id_i)) begin
                    m_st[issue_id_i] = commit_kill_i ? M_KIL : M_CMT;
                end else begin
                    m_st[issue_id_i] = M_ISS;
                end
                m_wb[issue_id_i] = issue_writeback_i;
            end
        end

        // sticky error on a commit with no matching entry
        @(negedge clk_i);
        idle();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 chk("err_after_rst", err_o, 0);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1);
        #1 chk("err_same_cycle", err_o, 0);
        @(negedge clk_i);
        idle();
        #1 chk("err_next", err_o, EXP_ERR);
        @(negedge clk_i);
        @(negedge clk_i);
        #1 chk("err_sticky", err_o, EXP_ERR);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cv32e40px_x_commit_tracker.md
Name: cv32e40px_x_commit_tracker

Overview:
- Coprocessor-side scoreboard on the CORE-V-XIF link, between the core's issue/commit channels and the coprocessor execution unit.
- Records every accepted offloaded instruction by id and tracks its commit or kill.
- Gates execution-unit results: committed results with writeback go to the core's result channel through a one-deep output register; killed results are dropped.
- Frees the entry when the result retires.

Parameters:
- X_ID_WIDTH, 4, width of instruction id.
- DEPTH, 4, number of outstanding-instruction slots (1..16).
- X_RFW_WIDTH, 32, result data width; multiple of 32.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- issue_valid_i  in  1  issue transaction valid
- issue_ready_o  out  1  tracker can take issue transaction
- issue_id_i  in  X_ID_WIDTH  id of issued instruction
- issue_accept_i  in  1  coprocessor decoder accepts instruction
- issue_writeback_i  in  1  accepted instruction writes rd
- commit_valid_i  in  1  commit transaction valid (no ready)
- commit_id_i  in  X_ID_WIDTH  id being committed/killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- ex_valid_i  in  1  execution-unit result valid
- ex_ready_o  out  1  tracker consumes execution result
- ex_id_i  in  X_ID_WIDTH  result id
- ex_data_i  in  X_RFW_WIDTH  result data
- ex_rd_i  in  5  destination register
- ex_we_i  in  X_RFW_WIDTH/32  write enables
- result_valid_o  out  1  result to core valid
- result_ready_i  in  1  core accepts result
- result_id_o  out  X_ID_WIDTH  result id
- result_data_o  out  X_RFW_WIDTH  result data
- result_rd_o  out  5  destination register
- result_we_o  out  X_RFW_WIDTH/32  write enables
- outstanding_o  out  $clog2(DEPTH+1)  number of non-FREE slots
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: all slots FREE; outputs result_valid_o=0, result_id_o/data_o/rd_o/we_o=0, outstanding_o=0, err_o=0. Reset mid-operation discards all entries and the output register immediately.
- Slot state per entry: FREE, ISSUED, COMMITTED, KILLED. Each slot also stores id and wb (issue_writeback_i).
- issue_ready_o = (at least one FREE slot) AND (issue_id_i not held by any non-FREE slot). It is combinational from slot state.
- Issue handshake (issue_valid_i & issue_ready_o):
  - If issue_accept_i=1, allocate the lowest-index FREE slot in state ISSUED.
  - If issue_accept_i=0, allocate nothing.
- Commit transaction:
  - Matches the non-FREE slot with equal id.
  - ISSUED -> COMMITTED (kill=0) or KILLED (kill=1).
  - Commit to a COMMITTED/KILLED slot, or to an unmatched id, is ignored (error if enabled).
- Same-cycle issue handshake and commit with the same id: the new slot is allocated directly as COMMITTED or KILLED.
- ex_ready_o (combinational) when ex_valid_i and the matching slot is:
  - KILLED: 1. Result dropped, slot -> FREE next cycle.
  - COMMITTED with wb=0: 1. Dropped, slot -> FREE.
  - COMMITTED with wb=1: 1 only if the output register is empty or result_ready_i=1. Data loaded into the output register, slot -> FREE.
  - ISSUED: 0. Stall until commit is seen; state is registered, so there is a minimum 1 cycle after the commit.
  - No match: 0 (error if enabled).
- Output register: loaded on an ex handshake, so result_valid_o rises the cycle after (latency 1). Cleared on result_valid_o & result_ready_i unless reloaded the same cycle; back-to-back throughput is 1/cycle. result_* are held stable while valid & !ready.
- Freeing a slot and issuing into it in the same cycle is legal: the freed slot is visible as FREE only from the next cycle.
- Commit and ex result for the same ISSUED slot in the same cycle: ex stalls one cycle, then follows the rule for the new state.
- outstanding_o counts non-FREE slots, updated each cycle from the registered state.

Optional Feature:
- Macro CV32E40PX_X_COMMIT_TRACKER_ERR_EN.
- Defined: err_o is set, and stays set until reset, on any of:
  - commit to an unmatched id;
  - commit to an already committed/killed slot;
  - ex_valid_i with an unmatched id;
  - issue_valid_i held while the id is live for more than 2 cycles.
- Undefined: err_o is tied to 0 and no detection logic is built; all other behaviour is identical.

Test Plan:
- Issue id 3 (accept=1, wb=1), commit id 3 kill=0, ex id 3 data 0xDEADBEEF rd 5 -> result_valid_o one cycle after the ex handshake with id 3, data 0xDEADBEEF, rd 5; outstanding_o 1->0.
- Issue id 2, ex id 2 presented before commit -> ex_ready_o=0 until commit id 2 arrives, then handshake; result delivered.
- Issue id 1, commit id 1 kill=1, ex id 1 -> ex_ready_o=1, no result_valid_o pulse, slot freed.
- Issue ids 0..3 (DEPTH=4), issue id 4 -> issue_ready_o=0 until one result retires; then id 4 accepted next cycle.
- Hold result_ready_i=0 with committed ex ids 5 and 6 queued -> result_* stable on id 5, ex_ready_o=0 for id 6; release -> id 5 then id 6 on consecutive cycles.
- With CV32E40PX_X_COMMIT_TRACKER_ERR_EN, commit id 9 with no entry -> err_o=1 next cycle and sticky; without the macro err_o stays 0.
